// File: rtl/eu_dispatch.sv
// EU instruction dispatcher: accepts FETCH/EXEC instructions, strobes the target
// execution units for one cycle, then waits for their completion or a timeout.

module eu_done_lane (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  input  logic done,
  input  logic mask_bit,
  output logic ok
);
  logic cap;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   cap <= 1'b0;
    else if (clr) cap <= 1'b0;
    else if (en)  cap <= cap | done;
  end

  // The live done bit counts too, so completion is seen in the cycle it arrives.
  assign ok = cap | done | ~mask_bit;
endmodule

module eu_dispatch #(
  parameter int TIMEOUT_W = 16,
  parameter int EXEC_W    = 28
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [1:0]        instr_op,
  input  logic [31:0]       instr_mask,
  input  logic [31:0]       instr_addr,
  input  logic [4:0]        instr_sel,
  output logic [31:0]       eu_fetch,
  output logic [31:0]       eu_exec,
  output logic [31:0]       eu_fetch_addr,
  output logic [4:0]        sdram_read_sel,
  input  logic              fetch_done,
  input  logic [EXEC_W-1:0] exec_done,
  output logic              busy,
  output logic              err_timeout,
  input  logic              err_clr
);
  localparam logic [1:0] OP_FETCH = 2'b01;
  localparam logic [1:0] OP_EXEC  = 2'b10;
  localparam logic [TIMEOUT_W-1:0] CNT_MAX  = '1;
  localparam logic [TIMEOUT_W-1:0] CNT_LAST = CNT_MAX - 1'b1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

  state_t                state_q, state_d;
  logic                  exec_q;
  logic [31:0]           mask_q;
  logic [TIMEOUT_W-1:0]  cnt_q;
  logic [EXEC_W-1:0]     lane_ok;
  logic                  accept, is_work, start, complete, timeout_hit;

  assign instr_ready = (state_q == S_IDLE);
  assign busy        = (state_q != S_IDLE);
  assign accept      = instr_valid & instr_ready;
  assign is_work     = (instr_op == OP_FETCH) || (instr_op == OP_EXEC);
  assign start       = accept & is_work & (|instr_mask);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      eu_fetch_addr  <= '0;
      sdram_read_sel <= '0;
    end else if (accept && is_work) begin
      eu_fetch_addr  <= instr_addr;
      sdram_read_sel <= instr_sel;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask_q <= '0;
      exec_q <= 1'b0;
    end else if (start) begin
      mask_q <= instr_mask;
      exec_q <= (instr_op == OP_EXEC);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                   cnt_q <= '0;
    else if (state_q == S_ISSUE)                  cnt_q <= '0;
    else if (state_q == S_WAIT && cnt_q != CNT_MAX) cnt_q <= cnt_q + 1'b1;
  end

  // Capture is cleared in ISSUE so done bits seen there are discarded.
  for (genvar i = 0; i < EXEC_W; i++) begin : g_lane
    eu_done_lane u_lane (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr      (state_q == S_ISSUE),
      .en       (state_q == S_WAIT),
      .done     (exec_done[i]),
      .mask_bit (mask_q[i]),
      .ok       (lane_ok[i])
    );
  end

  assign complete    = exec_q ? (&lane_ok) : fetch_done;
  // Counter reaches its maximum on this cycle's increment; completion takes priority.
  assign timeout_hit = (state_q == S_WAIT) && !complete && (cnt_q >= CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           err_timeout <= 1'b0;
    else if (timeout_hit) err_timeout <= 1'b1;
    else if (err_clr)     err_timeout <= 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_ISSUE;
      S_ISSUE: state_d = S_WAIT;
      S_WAIT:  if (complete || timeout_hit) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign eu_fetch = (state_q == S_ISSUE && !exec_q) ? mask_q : '0;
  assign eu_exec  = (state_q == S_ISSUE &&  exec_q) ? mask_q : '0;
endmodule

// File: tb/tb_eu_dispatch.sv
// Directed bench for eu_dispatch; small TIMEOUT_W keeps timeout scenarios short.

module tb_eu_dispatch;
  localparam int TW = 4;
  localparam int EW = 28;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          instr_valid = 1'b0;
  logic          instr_ready;
  logic [1:0]    instr_op = '0;
  logic [31:0]   instr_mask = '0;
  logic [31:0]   instr_addr = '0;
  logic [4:0]    instr_sel = '0;
  logic [31:0]   eu_fetch, eu_exec, eu_fetch_addr;
  logic [4:0]    sdram_read_sel;
  logic          fetch_done = 1'b0;
  logic [EW-1:0] exec_done = '0;
  logic          busy, err_timeout;
  logic          err_clr = 1'b0;

  int checks = 0;
  int errors = 0;

  eu_dispatch #(.TIMEOUT_W(TW), .EXEC_W(EW)) dut (
    .clk(clk), .rst_n(rst_n),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_op(instr_op), .instr_mask(instr_mask),
    .instr_addr(instr_addr), .instr_sel(instr_sel),
    .eu_fetch(eu_fetch), .eu_exec(eu_exec),
    .eu_fetch_addr(eu_fetch_addr), .sdram_read_sel(sdram_read_sel),
    .fetch_done(fetch_done), .exec_done(exec_done),
    .busy(busy), .err_timeout(err_timeout), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Offers one instruction; returns #1 after the accepting edge.
  task automatic offer(input logic [1:0] op, input logic [31:0] m,
                       input logic [31:0] a, input logic [4:0] s);
    instr_valid = 1'b1; instr_op = op; instr_mask = m; instr_addr = a; instr_sel = s;
    tick();
    instr_valid = 1'b0; instr_op = 2'b00; instr_mask = '0;
  endtask

  task automatic test_reset();
    #2;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", busy); end
    checks++; if (eu_fetch !== 32'h0 || eu_exec !== 32'h0) begin errors++; $display("FAIL rst_strobe got %h/%h exp 0", eu_fetch, eu_exec); end
    checks++; if (eu_fetch_addr !== 32'h0 || sdram_read_sel !== 5'h0) begin errors++; $display("FAIL rst_addr got %h/%h exp 0", eu_fetch_addr, sdram_read_sel); end
    checks++; if (err_timeout !== 1'b0) begin errors++; $display("FAIL rst_err got %b exp 0", err_timeout); end
    tick(); tick();
    rst_n = 1'b1;
    tick();
    checks++; if (instr_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got %b exp 1", instr_ready); end
  endtask

  task automatic test_fetch();
    offer(2'b01, 32'h1, 32'h1000, 5'd3);
    checks++; if (eu_fetch !== 32'h1 || eu_exec !== 32'h0) begin errors++; $display("FAIL fetch_strobe got %h/%h exp 1/0", eu_fetch, eu_exec); end
    checks++; if (eu_fetch_addr !== 32'h1000 || sdram_read_sel !== 5'd3) begin errors++; $display("FAIL fetch_addr got %h/%h exp 1000/3", eu_fetch_addr, sdram_read_sel); end
    checks++; if (busy !== 1'b1 || instr_ready !== 1'b0) begin errors++; $display("FAIL fetch_busy got %b/%b exp 1/0", busy, instr_ready); end
    repeat (4) tick();
    checks++; if (eu_fetch !== 32'h0 || busy !== 1'b1) begin errors++; $display("FAIL fetch_wait got %h/%b exp 0/1", eu_fetch, busy); end
    tick();
    fetch_done = 1'b1;
    tick();
    fetch_done = 1'b0;
    checks++; if (busy !== 1'b0 || instr_ready !== 1'b1) begin errors++; $display("FAIL fetch_done got %b/%b exp 0/1", busy, instr_ready); end
    checks++; if (eu_fetch_addr !== 32'h1000 || sdram_read_sel !== 5'd3) begin errors++; $display("FAIL fetch_hold got %h/%h exp 1000/3", eu_fetch_addr, sdram_read_sel); end
  endtask

  task automatic test_exec_partial();
    offer(2'b10, 32'hF, 32'h2000, 5'd7);
    checks++; if (eu_exec !== 32'hF || eu_fetch !== 32'h0) begin errors++; $display("FAIL exec_strobe got %h/%h exp f/0", eu_exec, eu_fetch); end
    tick(); tick();
    exec_done = 28'h5;
    tick();
    exec_done = '0;
    checks++; if (busy !== 1'b1 || eu_exec !== 32'h0) begin errors++; $display("FAIL exec_half got %b/%h exp 1/0", busy, eu_exec); end
    tick(); tick(); tick();
    exec_done = 28'hA;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL exec_before got %b exp 1", busy); end
    tick();
    exec_done = '0;
    checks++; if (busy !== 1'b0 || instr_ready !== 1'b1) begin errors++; $display("FAIL exec_done got %b/%b exp 0/1", busy, instr_ready); end
    checks++; if (eu_fetch_addr !== 32'h2000 || sdram_read_sel !== 5'd7) begin errors++; $display("FAIL exec_addr got %h/%h exp 2000/7", eu_fetch_addr, sdram_read_sel); end
  endtask

  task automatic test_timeout();
    offer(2'b10, 32'h3, 32'h0, 5'd0);
    exec_done = 28'h3;
    tick();
    exec_done = '0;
    repeat (14) tick();
    checks++; if (busy !== 1'b1 || err_timeout !== 1'b0) begin errors++; $display("FAIL to_early got %b/%b exp 1/0", busy, err_timeout); end
    tick();
    checks++; if (busy !== 1'b0 || err_timeout !== 1'b1) begin errors++; $display("FAIL to_set got %b/%b exp 0/1", busy, err_timeout); end
  endtask

  task automatic test_highmask_nop();
    offer(2'b10, 32'hF000_0001, 32'h4000, 5'd1);
    checks++; if (eu_exec !== 32'hF000_0001) begin errors++; $display("FAIL hm_strobe got %h exp f0000001", eu_exec); end
    tick();
    exec_done = 28'h1;
    tick();
    exec_done = '0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL hm_done got %b exp 0", busy); end
    checks++; if (err_timeout !== 1'b1) begin errors++; $display("FAIL hm_err got %b exp 1", err_timeout); end
    offer(2'b00, 32'hFF, 32'h0, 5'd0);
    checks++; if (busy !== 1'b0 || eu_fetch !== 32'h0 || eu_exec !== 32'h0) begin errors++; $display("FAIL nop got %b/%h/%h exp 0/0/0", busy, eu_fetch, eu_exec); end
    offer(2'b01, 32'h0, 32'h0, 5'd0);
    checks++; if (busy !== 1'b0 || eu_fetch !== 32'h0) begin errors++; $display("FAIL zmask got %b/%h exp 0/0", busy, eu_fetch); end
    offer(2'b11, 32'hF, 32'h0, 5'd0);
    checks++; if (busy !== 1'b0 || eu_fetch !== 32'h0 || eu_exec !== 32'h0) begin errors++; $display("FAIL rsvd got %b/%h/%h exp 0/0/0", busy, eu_fetch, eu_exec); end
  endtask

  task automatic test_err_clr();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    checks++; if (err_timeout !== 1'b0) begin errors++; $display("FAIL clr got %b exp 0", err_timeout); end
    offer(2'b10, 32'h1, 32'h0, 5'd0);
    tick();
    repeat (14) tick();
    checks++; if (err_timeout !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL clr_pre got %b/%b exp 0/1", err_timeout, busy); end
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    checks++; if (err_timeout !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL set_wins got %b/%b exp 1/0", err_timeout, busy); end
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
  endtask

  task automatic test_back_to_back();
    offer(2'b01, 32'h2, 32'h5000, 5'd2);
    tick();
    fetch_done = 1'b1;
    tick();
    fetch_done = 1'b0;
    offer(2'b10, 32'h4, 32'h6000, 5'd4);
    checks++; if (eu_exec !== 32'h4 || eu_fetch_addr !== 32'h6000) begin errors++; $display("FAIL b2b_strobe got %h/%h exp 4/6000", eu_exec, eu_fetch_addr); end
    tick();
    exec_done = 28'h4;
    tick();
    exec_done = '0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_done got %b exp 0", busy); end
  endtask

  task automatic test_reset_mid();
    offer(2'b01, 32'h5, 32'h3000, 5'd9);
    tick();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy got %b exp 1", busy); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || eu_fetch !== 32'h0 || eu_fetch_addr !== 32'h0 || sdram_read_sel !== 5'h0) begin errors++; $display("FAIL mid_rst got %b/%h/%h/%h exp 0", busy, eu_fetch, eu_fetch_addr, sdram_read_sel); end
    tick();
    rst_n = 1'b1;
    tick();
    checks++; if (instr_ready !== 1'b1 || err_timeout !== 1'b0) begin errors++; $display("FAIL mid_ready got %b/%b exp 1/0", instr_ready, err_timeout); end
    repeat (3) tick();
    checks++; if (eu_fetch !== 32'h0 || busy !== 1'b0) begin errors++; $display("FAIL mid_quiet got %h/%b exp 0/0", eu_fetch, busy); end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_exec_partial();
    test_timeout();
    test_highmask_nop();
    test_err_clr();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
